pipe_hazard_ctrl: RTL and testbench

Central stall/flush controller for the five-stage pipeline. Each cycle it drives the write enables and bubble-insert (flush) strobes of the PC, IF/ID, ID/EX, EX/MEM and MEM/WB pipeline registers. It resolves load-use hazards, taken branches, instruction-memory and data-memory stalls, and HALT retirement. It also keeps a registered state machine and saturating stall/flush performance counters.

---
 rtl/pipe_hazard_ctrl.sv | 103 ++++++++++
 tb/tb_pipe_hazard_ctrl.sv | 223 ++++++++++++++++++++++
 2 files changed

// File: rtl/pipe_hazard_ctrl.sv
// rtl/pipe_hazard_ctrl.sv - stall/flush controller for the five-stage pipeline
module pipe_hazard_ctrl #(
    parameter int REG_W = 3,
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [REG_W-1:0] id_rs,
    input  logic [REG_W-1:0] id_rt,
    input  logic             id_rs_vld,
    input  logic             id_rt_vld,
    input  logic             ex_memread,
    input  logic [REG_W-1:0] ex_rd,
    input  logic             ex_br_taken,
    input  logic             imem_stall,
    input  logic             dmem_stall,
    input  logic             mem_halt,
    output logic             pc_en,
    output logic             if_id_en,
    output logic             id_ex_en,
    output logic             ex_mem_en,
    output logic             mem_wb_en,
    output logic             if_id_flush,
    output logic             id_ex_flush,
    output logic             halted,
    output logic [CNT_W-1:0] stall_cnt,
    output logic [CNT_W-1:0] flush_cnt
);

    typedef enum logic [1:0] {RUN, DMEM_WAIT, DRAIN, HALT} state_t;

    state_t     state;
    state_t     state_nxt;
    logic [4:0] en;
    logic       load_use;

    assign load_use = ex_memread &&
                      ((id_rs_vld && (id_rs == ex_rd)) || (id_rt_vld && (id_rt == ex_rd)));

    assign {pc_en, if_id_en, id_ex_en, ex_mem_en, mem_wb_en} = en;
    assign halted = (state == HALT);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state <= RUN;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        en          = 5'b11111;
        if_id_flush = 1'b0;
        id_ex_flush = 1'b0;
        state_nxt   = state;
        if (state == HALT) begin
            en = 5'b00000;
        end else if ((state == DMEM_WAIT) && dmem_stall) begin
            en = 5'b00000;
        end else if (mem_halt) begin
            en        = 5'b00000;
            state_nxt = HALT;
        end else if (dmem_stall) begin
            en        = 5'b00000;
            state_nxt = DMEM_WAIT;
        end else if (state == DRAIN) begin
            // Stale pre-branch fetch: keep PC on the target, squash whatever lands in IF/ID
            en          = 5'b01111;
            if_id_flush = 1'b1;
            state_nxt   = imem_stall ? DRAIN : RUN;
        end else if (ex_br_taken) begin
            if_id_flush = 1'b1;
            id_ex_flush = 1'b1;
            state_nxt   = imem_stall ? DRAIN : RUN;
        end else if (load_use) begin
            // IF/ID is held, so a concurrent imem_stall needs no separate handling
            en          = 5'b00111;
            id_ex_flush = 1'b1;
            state_nxt   = RUN;
        end else if (imem_stall) begin
            en          = 5'b01111;
            if_id_flush = 1'b1;
            state_nxt   = RUN;
        end else begin
            state_nxt = RUN;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            stall_cnt <= '0;
            flush_cnt <= '0;
        end else if (state != HALT) begin
            if (!pc_en && (stall_cnt != {CNT_W{1'b1}})) begin
                stall_cnt <= stall_cnt + CNT_W'(1);
            end
            if ((if_id_flush || id_ex_flush) && (flush_cnt != {CNT_W{1'b1}})) begin
                flush_cnt <= flush_cnt + CNT_W'(1);
            end
        end
    end

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// tb/tb_pipe_hazard_ctrl.sv - scoreboard bench for pipe_hazard_ctrl
module tb_pipe_hazard_ctrl;

    localparam int REG_W  = 3;
    localparam int CNT_W  = 16;
    localparam int MAXC   = (1 << CNT_W) - 1;
    localparam int M_RUN   = 0;
    localparam int M_DWAIT = 1;
    localparam int M_DRAIN = 2;
    localparam int M_HALT  = 3;

    logic             clk = 1'b0;
    logic             rst = 1'b0;
    logic [REG_W-1:0] id_rs = '0;
    logic [REG_W-1:0] id_rt = '0;
    logic             id_rs_vld = 1'b0;
    logic             id_rt_vld = 1'b0;
    logic             ex_memread = 1'b0;
    logic [REG_W-1:0] ex_rd = '0;
    logic             ex_br_taken = 1'b0;
    logic             imem_stall = 1'b0;
    logic             dmem_stall = 1'b0;
    logic             mem_halt = 1'b0;
    logic             pc_en, if_id_en, id_ex_en, ex_mem_en, mem_wb_en;
    logic             if_id_flush, id_ex_flush, halted;
    logic [CNT_W-1:0] stall_cnt, flush_cnt;

    pipe_hazard_ctrl #(.REG_W(REG_W), .CNT_W(CNT_W)) dut (
        .clk(clk), .rst(rst),
        .id_rs(id_rs), .id_rt(id_rt), .id_rs_vld(id_rs_vld), .id_rt_vld(id_rt_vld),
        .ex_memread(ex_memread), .ex_rd(ex_rd), .ex_br_taken(ex_br_taken),
        .imem_stall(imem_stall), .dmem_stall(dmem_stall), .mem_halt(mem_halt),
        .pc_en(pc_en), .if_id_en(if_id_en), .id_ex_en(id_ex_en),
        .ex_mem_en(ex_mem_en), .mem_wb_en(mem_wb_en),
        .if_id_flush(if_id_flush), .id_ex_flush(id_ex_flush), .halted(halted),
        .stall_cnt(stall_cnt), .flush_cnt(flush_cnt)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [4:0] en;
        logic [1:0] fl;
        logic       hlt;
        int         stall;
        int         flush;
    } exp_t;

    exp_t sb[$];
    int   tests = 0;
    int   fails = 0;
    int   m_mode = M_RUN;
    int   m_stall = 0;
    int   m_flush = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference: pipeline-level rules applied to one cycle of inputs
    task automatic drive(input logic memread, input logic [REG_W-1:0] rd,
                         input logic [REG_W-1:0] rs, input logic rsv,
                         input logic [REG_W-1:0] rt, input logic rtv,
                         input logic br, input logic imem, input logic dmem,
                         input logic halt);
        logic [4:0] en;
        logic [1:0] fl;
        logic       hz;
        int         nxt;
        exp_t       e;
        @(posedge clk);
        #1;
        ex_memread = memread; ex_rd = rd; id_rs = rs; id_rs_vld = rsv;
        id_rt = rt; id_rt_vld = rtv; ex_br_taken = br; imem_stall = imem;
        dmem_stall = dmem; mem_halt = halt;
        hz  = memread && ((rsv && (rs == rd)) || (rtv && (rt == rd)));
        en  = 5'b11111;
        fl  = 2'b00;
        nxt = M_RUN;
        if (m_mode == M_HALT) begin
            en = 5'b00000; nxt = M_HALT;
        end else if (m_mode == M_DWAIT && dmem) begin
            en = 5'b00000; nxt = M_DWAIT;
        end else if (halt) begin
            en = 5'b00000; nxt = M_HALT;
        end else if (dmem) begin
            en = 5'b00000; nxt = M_DWAIT;
        end else if (m_mode == M_DRAIN) begin
            en = 5'b01111; fl = 2'b10; nxt = imem ? M_DRAIN : M_RUN;
        end else if (br) begin
            fl = 2'b11; nxt = imem ? M_DRAIN : M_RUN;
        end else if (hz) begin
            en = 5'b00111; fl = 2'b01;
        end else if (imem) begin
            en = 5'b01111; fl = 2'b10;
        end
        e.en    = en;
        e.fl    = fl;
        e.hlt   = (m_mode == M_HALT);
        e.stall = m_stall;
        e.flush = m_flush;
        sb.push_back(e);
        if (m_mode != M_HALT) begin
            if (!en[4] && m_stall < MAXC) m_stall++;
            if (fl != 2'b00 && m_flush < MAXC) m_flush++;
        end
        m_mode = nxt;
    endtask

    task automatic drive_idle();
        drive(1'b0, 3'd0, 3'd0, 1'b0, 3'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    endtask

    task automatic drive_rand(input logic allow_halt);
        drive($urandom_range(0, 9) < 4, 3'($urandom_range(0, 7)), 3'($urandom_range(0, 7)),
              $urandom_range(0, 9) < 7, 3'($urandom_range(0, 7)), $urandom_range(0, 9) < 7,
              $urandom_range(0, 99) < 15, $urandom_range(0, 99) < 25,
              $urandom_range(0, 99) < 8, allow_halt && ($urandom_range(0, 99) < 20));
    endtask

    task automatic reset_pulse(input string tag);
        @(negedge clk);
        #2;
        ex_memread = 0; ex_rd = 0; id_rs = 0; id_rs_vld = 0; id_rt = 0; id_rt_vld = 0;
        ex_br_taken = 0; imem_stall = 0; dmem_stall = 0; mem_halt = 0;
        rst = 1'b0;
        #1;
        chk({tag, "_stall_cnt"}, 64'(stall_cnt), 64'(0));
        chk({tag, "_flush_cnt"}, 64'(flush_cnt), 64'(0));
        chk({tag, "_halted"}, 64'(halted), 64'(0));
        chk({tag, "_en"}, 64'({pc_en, if_id_en, id_ex_en, ex_mem_en, mem_wb_en}), 64'(5'b11111));
        chk({tag, "_flush"}, 64'({if_id_flush, id_ex_flush}), 64'(0));
        @(negedge clk);
        #1;
        rst = 1'b1;
        m_mode = M_RUN; m_stall = 0; m_flush = 0;
    endtask

    always @(negedge clk) begin
        if (sb.size() > 0) begin
            exp_t e;
            e = sb.pop_front();
            chk("enables", 64'({pc_en, if_id_en, id_ex_en, ex_mem_en, mem_wb_en}), 64'(e.en));
            chk("flushes", 64'({if_id_flush, id_ex_flush}), 64'(e.fl));
            chk("halted", 64'(halted), 64'(e.hlt));
            chk("stall_cnt", 64'(stall_cnt), 64'(e.stall));
            chk("flush_cnt", 64'(flush_cnt), 64'(e.flush));
        end
    end

    initial begin
        #1_500_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        #2;
        chk("rst_en", 64'({pc_en, if_id_en, id_ex_en, ex_mem_en, mem_wb_en}), 64'(5'b11111));
        chk("rst_flush", 64'({if_id_flush, id_ex_flush}), 64'(0));
        chk("rst_halted", 64'(halted), 64'(0));
        chk("rst_stall_cnt", 64'(stall_cnt), 64'(0));
        chk("rst_flush_cnt", 64'(flush_cnt), 64'(0));
        @(negedge clk);
        #1;
        rst = 1'b1;

        // load-use on rs, then bubble
        drive(1'b1, 3'd3, 3'd3, 1'b1, 3'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        drive_idle();
        @(negedge clk);
        #1;
        chk("lu_stall_cnt", 64'(stall_cnt), 64'(1));
        chk("lu_flush_cnt", 64'(flush_cnt), 64'(1));

        // matching registers but sources not read
        drive(1'b1, 3'd3, 3'd3, 1'b0, 3'd3, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        // load-use together with imem_stall
        drive(1'b1, 3'd5, 3'd1, 1'b0, 3'd5, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0);

        for (int i = 0; i < 4; i++) drive(1'b0, 3'd0, 3'd0, 1'b0, 3'd0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
        drive_idle();

        // taken branch during an I-miss, miss held two more cycles
        drive(1'b0, 3'd0, 3'd0, 1'b0, 3'd0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0);
        for (int i = 0; i < 2; i++) drive(1'b0, 3'd0, 3'd0, 1'b0, 3'd0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
        drive_idle();
        drive_idle();

        for (int i = 0; i < 3000; i++) drive_rand(1'b0);

        reset_pulse("mid_run_rst");

        for (int i = 0; i < MAXC + 6; i++) drive(1'b0, 3'd0, 3'd0, 1'b0, 3'd0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
        @(negedge clk);
        #1;
        chk("sat_stall_cnt", 64'(stall_cnt), 64'(16'hFFFF));
        chk("sat_flush_cnt", 64'(flush_cnt), 64'(16'hFFFF));

        reset_pulse("sat_rst");

        for (int i = 0; i < 20; i++) drive_rand(1'b0);
        // HALT wins over a simultaneous data-memory stall
        drive(1'b0, 3'd0, 3'd0, 1'b0, 3'd0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1);
        for (int i = 0; i < 10; i++) drive_rand(1'b1);
        @(negedge clk);
        #1;
        chk("halt_sticky", 64'(halted), 64'(1));

        reset_pulse("halt_rst");
        for (int i = 0; i < 50; i++) drive_rand(1'b0);
        @(negedge clk);
        #1;

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
